// File: rtl/axi_test_sequencer_if.sv
// Host/gen-chk signal bundle for the test sequencer.
// slave is the sequencer view; master is the host plus gen/chk view that drives the inputs.
interface axi_test_sequencer_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 i_go;
  logic                 i_abort;
  logic                 o_start;
  logic                 i_fail;
  logic                 i_test_complete;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_pass;
  logic                 o_fail_sticky;
  logic                 o_timeout;
  logic [CNT_WIDTH-1:0] o_run_count;
  logic [CNT_WIDTH-1:0] o_fail_count;

  modport slave (
    input  i_go, i_abort, i_fail, i_test_complete,
    output o_start, o_busy, o_done, o_pass, o_fail_sticky, o_timeout,
    output o_run_count, o_fail_count
  );

  modport master (
    output i_go, i_abort, i_fail, i_test_complete,
    input  o_start, o_busy, o_done, o_pass, o_fail_sticky, o_timeout,
    input  o_run_count, o_fail_count
  );
endinterface

// File: rtl/axi_test_sequencer.sv
// Sequences NUM_RUNS gen/chk passes with idle gaps and a per-pass watchdog,
// accumulating run/fail counts and a final pass/fail verdict.
module axi_test_sequencer #(
  parameter int NUM_RUNS       = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int GAP_CYCLES     = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  axi_test_sequencer_if.slave  bus
);

  localparam int GAP_EFF = (GAP_CYCLES < 4) ? 4 : GAP_CYCLES;
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W   = $clog2(GAP_EFF);

  localparam logic [WD_W-1:0]      WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST   = GAP_W'(GAP_EFF - 1);
  localparam logic [CNT_WIDTH-1:0] RUN_TARGET = CNT_WIDTH'(NUM_RUNS);
  localparam logic                 CONTINUOUS = (NUM_RUNS == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t               state_r;
  logic                 go_q_r;
  logic                 fail_latch_r;
  logic [WD_W-1:0]      wd_r;
  logic [GAP_W-1:0]     gap_cnt_r;
  logic                 start_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 pass_r;
  logic                 fail_sticky_r;
  logic                 timeout_r;
  logic [CNT_WIDTH-1:0] run_count_r;
  logic [CNT_WIDTH-1:0] fail_count_r;

  logic go_edge_s;
  logic pass_failed_s;
  logic runs_done_s;

  assign go_edge_s     = bus.i_go & ~go_q_r;
  assign pass_failed_s = fail_latch_r | bus.i_fail;
  assign runs_done_s   = ~CONTINUOUS & (run_count_r == RUN_TARGET);

  // Sequencer FSM with all status outputs registered alongside the state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r       <= IDLE;
      go_q_r        <= 1'b1;
      fail_latch_r  <= 1'b0;
      wd_r          <= '0;
      gap_cnt_r     <= '0;
      start_r       <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      fail_sticky_r <= 1'b0;
      timeout_r     <= 1'b0;
      run_count_r   <= '0;
      fail_count_r  <= '0;
    end else begin
      go_q_r <= bus.i_go;
      if (bus.i_abort) begin
        // Counts and sticky flags stay visible for readback after an abort.
        state_r <= IDLE;
        start_r <= 1'b0;
        busy_r  <= 1'b0;
        done_r  <= 1'b0;
        pass_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE, DONE: begin
            if (go_edge_s) begin
              state_r       <= RUN;
              start_r       <= 1'b1;
              busy_r        <= 1'b1;
              done_r        <= 1'b0;
              pass_r        <= 1'b0;
              fail_sticky_r <= 1'b0;
              timeout_r     <= 1'b0;
              run_count_r   <= '0;
              fail_count_r  <= '0;
              fail_latch_r  <= 1'b0;
              wd_r          <= '0;
            end
          end
          RUN: begin
            // A complete on the watchdog's last cycle still counts as a normal pass.
            if (bus.i_test_complete) begin
              run_count_r <= run_count_r + CNT_WIDTH'(1);
              if (pass_failed_s) begin
                fail_count_r  <= sat_inc(fail_count_r);
                fail_sticky_r <= 1'b1;
              end
              start_r   <= 1'b0;
              gap_cnt_r <= '0;
              state_r   <= GAP;
            end else if (wd_r == WD_LAST) begin
              timeout_r    <= 1'b1;
              fail_count_r <= sat_inc(fail_count_r);
              start_r      <= 1'b0;
              busy_r       <= 1'b0;
              done_r       <= 1'b1;
              pass_r       <= 1'b0;
              state_r      <= DONE;
            end else begin
              wd_r <= wd_r + WD_W'(1);
              if (bus.i_fail) begin
                fail_latch_r <= 1'b1;
              end
            end
          end
          GAP: begin
            if (gap_cnt_r == GAP_LAST) begin
              if (runs_done_s) begin
                state_r <= DONE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                pass_r  <= (fail_count_r == '0) & ~timeout_r;
              end else begin
                state_r      <= RUN;
                start_r      <= 1'b1;
                wd_r         <= '0;
                fail_latch_r <= 1'b0;
              end
            end else begin
              gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_start       = start_r;
  assign bus.o_busy        = busy_r;
  assign bus.o_done        = done_r;
  assign bus.o_pass        = pass_r;
  assign bus.o_fail_sticky = fail_sticky_r;
  assign bus.o_timeout     = timeout_r;
  assign bus.o_run_count   = run_count_r;
  assign bus.o_fail_count  = fail_count_r;

endmodule
